change_dispenser: RTL and testbench

//  Coin payout engine on the output side of the vending controller: accepts a change

---
 rtl/change_dispenser_if.sv | 34 +++
 rtl/change_dispenser.sv | 182 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, hopper, refill/fault and inventory bundle
// for the coin payout engine. master = controller side, slave = dispenser.
interface change_dispenser_if #(
  parameter int INV_W = 8
);
  logic             chng_valid;
  logic [4:0]       chng_amount;
  logic             chng_ready;
  logic             hopper_ack;
  logic             out10;
  logic             out50;
  logic             outa0;
  logic             done;
  logic             fault;
  logic             jam;
  logic [4:0]       short_amt;
  logic             refill;
  logic             fault_clr;
  logic [INV_W-1:0] n10;
  logic [INV_W-1:0] n50;
  logic [INV_W-1:0] na0;

  modport master (
    output chng_valid, chng_amount, hopper_ack, refill, fault_clr,
    input  chng_ready, out10, out50, outa0, done, fault, jam,
    input  short_amt, n10, n50, na0
  );

  modport slave (
    input  chng_valid, chng_amount, hopper_ack, refill, fault_clr,
    output chng_ready, out10, out50, outa0, done, fault, jam,
    output short_amt, n10, n50, na0
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout engine with per-coin inventories.
// Optional hopper ack-timeout jam detection: define CHG_JAM_DETECT_EN.
module change_dispenser #(
  parameter int INV_W       = 8,
  parameter int INIT_N10    = 20,
  parameter int INIT_N50    = 10,
  parameter int INIT_NA0    = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_PULSE, S_WAIT, S_DONE, S_FAULT
  } state_t;

  typedef enum logic [1:0] {C10, C50, CA0} coin_t;

  localparam logic [INV_W-1:0] I10 = INV_W'(INIT_N10);
  localparam logic [INV_W-1:0] I50 = INV_W'(INIT_N50);
  localparam logic [INV_W-1:0] IA0 = INV_W'(INIT_NA0);
  localparam logic [INV_W-1:0] ONE = INV_W'(1);

  state_t           state_q, state_d;
  coin_t            coin_q, coin_d;
  logic [4:0]       rem_q, rem_d;
  logic [INV_W-1:0] n10_q, n10_d;
  logic [INV_W-1:0] n50_q, n50_d;
  logic [INV_W-1:0] na0_q, na0_d;

`ifdef CHG_JAM_DETECT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          jam_q, jam_d;
`endif

  // State, remaining amount and inventory registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      coin_q  <= C10;
      rem_q   <= '0;
      n10_q   <= I10;
      n50_q   <= I50;
      na0_q   <= IA0;
`ifdef CHG_JAM_DETECT_EN
      cnt_q   <= '0;
      jam_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      rem_q   <= rem_d;
      n10_q   <= n10_d;
      n50_q   <= n50_d;
      na0_q   <= na0_d;
`ifdef CHG_JAM_DETECT_EN
      cnt_q   <= cnt_d;
      jam_q   <= jam_d;
`endif
    end
  end

  // Next state: greedy coin choice, payout bookkeeping, refill/fault
  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    rem_d   = rem_q;
    n10_d   = n10_q;
    n50_d   = n50_q;
    na0_d   = na0_q;
`ifdef CHG_JAM_DETECT_EN
    cnt_d   = cnt_q;
    jam_d   = jam_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.chng_valid) begin
          rem_d   = bus.chng_amount;
          state_d = S_SELECT;
        end
        if (bus.refill) begin
          n10_d = I10;
          n50_d = I50;
          na0_d = IA0;
        end
      end
      S_SELECT: begin
        if (rem_q == 5'd0) begin
          state_d = S_DONE;
        end else if (rem_q >= 5'd10 && na0_q != '0) begin
          coin_d  = CA0;
          state_d = S_PULSE;
        end else if (rem_q >= 5'd5 && n50_q != '0) begin
          coin_d  = C50;
          state_d = S_PULSE;
        end else if (n10_q != '0) begin
          coin_d  = C10;
          state_d = S_PULSE;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_PULSE: begin
        state_d = S_WAIT;
`ifdef CHG_JAM_DETECT_EN
        cnt_d   = '0;
`endif
        case (coin_q)
          CA0: begin
            if (na0_q != '0) na0_d = na0_q - ONE;
            if (rem_q >= 5'd10) rem_d = rem_q - 5'd10;
          end
          C50: begin
            if (n50_q != '0) n50_d = n50_q - ONE;
            if (rem_q >= 5'd5) rem_d = rem_q - 5'd5;
          end
          default: begin
            if (n10_q != '0) n10_d = n10_q - ONE;
            if (rem_q >= 5'd1) rem_d = rem_q - 5'd1;
          end
        endcase
      end
      S_WAIT: begin
        if (bus.hopper_ack) begin
          state_d = S_SELECT;
        end
`ifdef CHG_JAM_DETECT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
          jam_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (bus.refill) begin
          n10_d   = I10;
          n50_d   = I50;
          na0_d   = IA0;
          state_d = S_SELECT;
`ifdef CHG_JAM_DETECT_EN
          jam_d   = 1'b0;
`endif
        end else if (bus.fault_clr) begin
          rem_d   = '0;
          state_d = S_IDLE;
`ifdef CHG_JAM_DETECT_EN
          jam_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.chng_ready = (state_q == S_IDLE);
  assign bus.out10      = (state_q == S_PULSE) && (coin_q == C10);
  assign bus.out50      = (state_q == S_PULSE) && (coin_q == C50);
  assign bus.outa0      = (state_q == S_PULSE) && (coin_q == CA0);
  assign bus.done       = (state_q == S_DONE);
  assign bus.fault      = (state_q == S_FAULT);
  assign bus.short_amt  = (state_q == S_FAULT) ? rem_q : 5'd0;
  assign bus.n10        = n10_q;
  assign bus.n50        = n50_q;
  assign bus.na0        = na0_q;
`ifdef CHG_JAM_DETECT_EN
  assign bus.jam        = (state_q == S_FAULT) && jam_q;
`else
  assign bus.jam        = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: three dispenser instances with different reset
// inventories, directed vectors, corner sequences and a greedy payout model.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] valid, ack, rfl, fclr;
  logic [4:0] amt [3];
  logic [2:0] o10, o50, oa0, dn, flt, jm, rdy;
  logic [4:0] shrt [3];
  logic [7:0] i10 [3];
  logic [7:0] i50 [3];
  logic [7:0] ia0 [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    change_dispenser_if #(.INV_W(8)) u_if ();
    change_dispenser #(
      .INV_W(8),
      .INIT_N10(g == 2 ? 1 : 20),
      .INIT_N50(g == 2 ? 0 : 10),
      .INIT_NA0(g == 0 ? 10 : 0),
      .ACK_TIMEOUT(16)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(u_if)
    );
    assign u_if.chng_valid  = valid[g];
    assign u_if.chng_amount = amt[g];
    assign u_if.hopper_ack  = ack[g];
    assign u_if.refill      = rfl[g];
    assign u_if.fault_clr   = fclr[g];
    assign o10[g]  = u_if.out10;
    assign o50[g]  = u_if.out50;
    assign oa0[g]  = u_if.outa0;
    assign dn[g]   = u_if.done;
    assign flt[g]  = u_if.fault;
    assign jm[g]   = u_if.jam;
    assign rdy[g]  = u_if.chng_ready;
    assign shrt[g] = u_if.short_amt;
    assign i10[g]  = u_if.n10;
    assign i50[g]  = u_if.n50;
    assign ia0[g]  = u_if.na0;
  end

  int nerr = 0;
  int nchk = 0;
  int got[$];
  int exp_q[$];
  int res_kind, res_k, first_pk;
  int minv [3][3];

  typedef struct {
    int d; int amt; int dly; int nc; int seq;
    int kind; int shrt; int e10; int e50; int ea0; int dk;
  } vec_t;

  task automatic chk(input string nm, input int act, input int ex);
    nchk++;
    if (act != ex) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, ex);
    end
  endtask

  task automatic chk_seq(input string nm);
    bit ok;
    ok = (got.size() == exp_q.size());
    if (ok) foreach (got[i]) if (got[i] != exp_q[i]) ok = 1'b0;
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got coins %p expected coins %p", nm, got, exp_q);
    end
  endtask

  function automatic void set_init(input int d);
    minv[d][0] = (d == 0) ? 10 : 0;
    minv[d][1] = (d == 2) ? 0 : 10;
    minv[d][2] = (d == 2) ? 1 : 20;
  endfunction

  function automatic int greedy(input int d, input int rem);
    int r;
    r = rem;
    while (r > 0) begin
      if (r >= 10 && minv[d][0] > 0) begin
        exp_q.push_back(10); minv[d][0]--; r -= 10;
      end else if (r >= 5 && minv[d][1] > 0) begin
        exp_q.push_back(5); minv[d][1]--; r -= 5;
      end else if (minv[d][2] > 0) begin
        exp_q.push_back(1); minv[d][2]--; r -= 1;
      end else begin
        break;
      end
    end
    return r;
  endfunction

  task automatic chk_inv(input string nm, input int d);
    chk({nm, "_n10"}, int'(i10[d]), minv[d][2]);
    chk({nm, "_n50"}, int'(i50[d]), minv[d][1]);
    chk({nm, "_na0"}, int'(ia0[d]), minv[d][0]);
  endtask

  task automatic start(input int d, input int a);
    @(negedge clk);
    chk("start_ready", int'(rdy[d]), 1);
    valid[d] = 1'b1;
    amt[d]   = 5'(a);
    @(posedge clk);
  endtask

  // Hopper behaviour: ack one cycle after each pulse plus dly (dly<0: never)
  task automatic run(input int d, input int dly, input int budget);
    int cnt, np;
    cnt = 0; res_kind = 0; res_k = -1; first_pk = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      valid[d] = 1'b0; rfl[d] = 1'b0; fclr[d] = 1'b0; ack[d] = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ack[d] = 1'b1;
      end
      np = int'(o10[d]) + int'(o50[d]) + int'(oa0[d]);
      if (np > 0) begin
        chk("onehot", np, 1);
        if (first_pk < 0) first_pk = k;
        if (oa0[d]) got.push_back(10);
        else if (o50[d]) got.push_back(5);
        else got.push_back(1);
        if (dly >= 0) cnt = dly + 1;
      end
      if (dn[d]) begin res_kind = 1; res_k = k; break; end
      if (flt[d]) begin res_kind = 2; res_k = k; break; end
    end
    ack[d] = 1'b0;
  endtask

  task automatic refill_resume(input int d);
    @(negedge clk);
    rfl[d] = 1'b1;
    @(posedge clk);
  endtask

  task automatic clear_fault(input int d);
    @(negedge clk);
    fclr[d] = 1'b1;
    @(negedge clk);
    fclr[d] = 1'b0;
    chk("clr_ready", int'(rdy[d]), 1);
    chk("clr_fault", int'(flt[d]), 0);
    chk("clr_short", int'(shrt[d]), 0);
  endtask

  task automatic refill_idle(input int d);
    @(negedge clk);
    rfl[d] = 1'b1;
    @(negedge clk);
    rfl[d] = 1'b0;
    set_init(d);
    chk_inv("idle_refill", d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) set_init(i);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [4];
    int   vd, va, vdly, left, nref;

    vt[0] = '{d:0, amt:17, dly:0, nc:4, seq:'h115a, kind:1, shrt:0,
              e10:18, e50:9, ea0:9, dk:-1};
    vt[1] = '{d:0, amt:0, dly:0, nc:0, seq:0, kind:1, shrt:0,
              e10:18, e50:9, ea0:9, dk:1};
    vt[2] = '{d:1, amt:12, dly:1, nc:4, seq:'h1155, kind:1, shrt:0,
              e10:18, e50:8, ea0:0, dk:-1};
    vt[3] = '{d:2, amt:3, dly:2, nc:1, seq:'h1, kind:2, shrt:2,
              e10:0, e50:0, ea0:0, dk:-1};

    rst = 1'b1;
    valid = '0; ack = '0; rfl = '0; fclr = '0;
    foreach (amt[i]) amt[i] = '0;
    for (int i = 0; i < 3; i++) set_init(i);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", int'(rdy[i]), 1);
      chk("rst_outs", int'({o10[i], o50[i], oa0[i], dn[i], flt[i], jm[i]}), 0);
      chk("rst_short", int'(shrt[i]), 0);
      chk_inv("rst", i);
    end
    rst = 1'b0;

    foreach (vt[i]) begin
      got.delete(); exp_q.delete();
      for (int j = 0; j < vt[i].nc; j++) exp_q.push_back((vt[i].seq >> (4 * j)) & 'hf);
      start(vt[i].d, vt[i].amt);
      run(vt[i].d, vt[i].dly, 200);
      chk("vec_kind", res_kind, vt[i].kind);
      chk_seq("vec_seq");
      if (vt[i].dk >= 0) chk("vec_done_lat", res_k, vt[i].dk);
      else chk("vec_first_pulse", first_pk, 1);
      if (vt[i].kind == 2) chk("vec_short", int'(shrt[vt[i].d]), vt[i].shrt);
      chk("vec_n10", int'(i10[vt[i].d]), vt[i].e10);
      chk("vec_n50", int'(i50[vt[i].d]), vt[i].e50);
      chk("vec_na0", int'(ia0[vt[i].d]), vt[i].ea0);
    end

    // Inventory of one 1-coin: each refill pays one more coin
    got.delete(); exp_q = '{1};
    refill_resume(2);
    run(2, 0, 50);
    chk("refill1_kind", res_kind, 2);
    chk_seq("refill1_seq");
    chk("refill1_short", int'(shrt[2]), 1);
    got.delete();
    refill_resume(2);
    run(2, 0, 50);
    chk("refill2_kind", res_kind, 1);
    chk_seq("refill2_seq");
    got.delete(); exp_q.delete();
    start(2, 3);
    run(2, 0, 20);
    chk("empty_kind", res_kind, 2);
    chk("empty_lat", res_k, 1);
    chk("empty_short", int'(shrt[2]), 3);
    chk_seq("empty_seq");
    clear_fault(2);

    // Ack during PULSE ignored; refill/valid outside IDLE ignored
    got.delete();
    start(0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("pulse_seen", int'(o10[0]), 1);
    ack[0] = 1'b1; rfl[0] = 1'b1; valid[0] = 1'b1; amt[0] = 5'd9;
    @(negedge clk);
    ack[0] = 1'b0; rfl[0] = 1'b0; valid[0] = 1'b0;
    @(negedge clk);
    chk("early_ack_done", int'(dn[0]), 0);
    chk("early_ack_ready", int'(rdy[0]), 0);
    chk("busy_refill_n10", int'(i10[0]), 17);
    ack[0] = 1'b1;
    run(0, 0, 10);
    chk("late_ack_kind", res_kind, 1);
    run(0, 0, 4);
    chk("ignored_valid_kind", res_kind, 0);
    chk("ignored_valid_coins", got.size(), 0);
    chk("ignored_valid_ready", int'(rdy[0]), 1);
    refill_idle(0);

    // Randomized payouts against the greedy model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      vd   = $urandom_range(0, 2);
      va   = $urandom_range(0, 31);
      vdly = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) refill_idle(vd);
      got.delete(); exp_q.delete();
      left = greedy(vd, va);
      start(vd, va);
      run(vd, vdly, 300);
      nref = 0;
      forever begin
        chk("rnd_kind", res_kind, (left == 0) ? 1 : 2);
        chk_seq("rnd_seq");
        chk_inv("rnd", vd);
        if (res_kind != 2) break;
        chk("rnd_short", int'(shrt[vd]), left);
        if (nref < 4 && $urandom_range(0, 1) == 1) begin
          nref++;
          set_init(vd);
          got.delete(); exp_q.delete();
          left = greedy(vd, left);
          refill_resume(vd);
          run(vd, vdly, 300);
        end else begin
          clear_fault(vd);
          break;
        end
      end
    end

    // Reset in the middle of a payout
    do_reset();
    got.delete();
    start(0, 20);
    run(0, -1, 4);
    chk("midrst_pulses", got.size(), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_outs", int'({o10[0], o50[0], oa0[0], dn[0], flt[0], jm[0]}), 0);
    chk("midrst_ready", int'(rdy[0]), 1);
    for (int i = 0; i < 3; i++) set_init(i);
    chk_inv("midrst", 0);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    run(0, 0, 6);
    chk("midrst_quiet_kind", res_kind, 0);
    chk("midrst_quiet_coins", got.size(), 0);

    // Hopper never acks
    got.delete(); exp_q = '{5};
    start(0, 5);
    run(0, -1, 40);
    chk_seq("jam_seq");
`ifdef CHG_JAM_DETECT_EN
    chk("jam_kind", res_kind, 2);
    chk("jam_lat", res_k, 18);
    chk("jam_flag", int'(jm[0]), 1);
    chk("jam_short", int'(shrt[0]), 0);
    clear_fault(0);
    chk("jam_cleared", int'(jm[0]), 0);
`else
    chk("nojam_kind", res_kind, 0);
    chk("nojam_flag", int'({jm[0], flt[0]}), 0);
    @(negedge clk);
    ack[0] = 1'b1;
    run(0, 0, 6);
    chk("nojam_done", res_kind, 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
